// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and op-class helper for alu_iter
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// rtl/alu_muldiv_core.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
// lo_o/hi_o expose the next-state words so the caller can capture the last iteration's result.
module alu_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_mul_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_q;
  logic             mul_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;

  // MUL: {acc,lo} shifts right, multiplier bits consumed from lo[0].
  // DIVU: {acc,lo} shifts left, remainder in acc, quotient bits enter lo[0].
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = {acc_q, lo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    acc_d    = acc_q;
    lo_d     = lo_q;
    if (mul_q) begin
      acc_d = mul_sum[WIDTH:1];
      lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (rem_sh >= {1'b0, b_q}) begin
      acc_d = rem_diff[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = rem_sh[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      mul_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      lo_q   <= '0;
      b_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      mul_q  <= is_mul_i;
      cnt_q  <= CW'(WIDTH);
      acc_q  <= '0;
      lo_q   <= a_i;
      b_q    <= b_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign done_o = busy_q && (cnt_q == CW'(1));
  assign lo_o   = lo_d;
  assign hi_o   = acc_d;

endmodule

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - multi-cycle ALU top: handshake FSM, single-cycle datapath, output registers
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, ovf_q, ovf_d, load_d;

  logic             accept;
  logic             core_done;
  logic [WIDTH-1:0] core_lo, core_hi;
  logic [WIDTH-1:0] alu_res, sum, diff;
  logic             alu_ovf;
  logic [SHW-1:0]   sh;

  assign accept = in_valid && in_ready;

  alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept && is_multicycle(op)),
    .is_mul_i (op == OP_MUL),
    .a_i      (a),
    .b_i      (b),
    .done_o   (core_done),
    .lo_o     (core_lo),
    .hi_o     (core_hi)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = is_multicycle(op) ? ST_BUSY : ST_DONE;
      ST_BUSY: if (core_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    sum     = a + b;
    diff    = a - b;
    sh      = b[SHW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = a << sh;
      OP_SRL:  alu_res = a >> sh;
      OP_SRA:  alu_res = $signed(a) >>> sh;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    load_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    ovf_d       = ovf_q;
    if (accept && !is_multicycle(op)) begin
      load_d      = 1'b1;
      result_d    = alu_res;
      result_hi_d = '0;
      ovf_d       = alu_ovf;
    end else if ((state_q == ST_BUSY) && core_done) begin
      load_d      = 1'b1;
      ovf_d       = 1'b0;
      result_hi_d = '0;
      case (op_q)
        OP_MUL: begin
          result_d    = core_lo;
          result_hi_d = core_hi;
        end
        OP_DIVU: result_d = core_lo;
        default: result_d = core_hi;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= OP_AND;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      if (accept) op_q <= op;
      if (load_d) begin
        result_q    <= result_d;
        result_hi_q <= result_hi_d;
        zero_q      <= (result_d == '0);
        ovf_q       <= ovf_d;
      end
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - directed self-checking bench for alu_iter at WIDTH=32
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result, result_hi;
  logic        zero, ovf;

  int total = 0;
  int bad   = 0;
  int lat;
  logic rdy_seen;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op; lat = cycles from accept cycle to first out_valid cycle.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rdy_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic check_out(input string tag, input logic [31:0] r, input logic [31:0] rh,
                           input logic z, input logic v, input int l);
    chk({tag, "_lat"}, 32'(lat), 32'(l));
    chk({tag, "_res"}, result, r);
    chk({tag, "_hi"}, result_hi, rh);
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, z});
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, v});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'h0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_hi", result_hi, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_in_ready", {31'b0, in_ready}, 32'd1);

    issue(4'b0010, 32'h7FFF_FFFF, 32'h1);  check_out("add_ovf", 32'h8000_0000, 0, 0, 1, 1); retire("add_ovf");
    issue(4'b0110, 32'd5, 32'd5);          check_out("sub_eq", 32'h0, 0, 1, 0, 1);           retire("sub_eq");
    issue(4'b0110, 32'h8000_0000, 32'h1);  check_out("sub_ovf", 32'h7FFF_FFFF, 0, 0, 1, 1);  retire("sub_ovf");
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1);  check_out("slt", 32'h1, 0, 0, 0, 1);              retire("slt");
    issue(4'b1011, 32'hFFFF_FFFF, 32'h1);  check_out("sltu", 32'h0, 0, 1, 0, 1);             retire("sltu");
    issue(4'b1010, 32'h8000_0000, 32'h21); check_out("sra", 32'hC000_0000, 0, 0, 0, 1);      retire("sra");
    issue(4'b1001, 32'h8000_0000, 32'h4);  check_out("srl", 32'h0800_0000, 0, 0, 0, 1);      retire("srl");
    issue(4'b1000, 32'h0000_0003, 32'h1F); check_out("sll", 32'h8000_0000, 0, 0, 0, 1);      retire("sll");
    issue(4'b1100, 32'h0, 32'h0);          check_out("nor", 32'hFFFF_FFFF, 0, 0, 0, 1);      retire("nor");
    issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00); check_out("and", 32'h00F0_1200, 0, 0, 0, 1); retire("and");
    issue(4'b0001, 32'hF000_0001, 32'h0000_0010); check_out("or", 32'hF000_0011, 0, 0, 0, 1);  retire("or");
    issue(4'b1111, 32'd5, 32'd9);          check_out("undef", 32'h0, 0, 1, 0, 1);            retire("undef");

    issue(4'b0011, 32'hFFFF_FFFF, 32'h2);
    check_out("mul", 32'hFFFF_FFFE, 32'h1, 0, 0, 33);
    chk("mul_busy_rdy", {31'b0, rdy_seen}, 32'd0);
    retire("mul");
    issue(4'b0011, 32'h1234_5678, 32'h1000_0000); check_out("mul2", 32'h8000_0000, 32'h0123_4567, 0, 0, 33); retire("mul2");
    issue(4'b0100, 32'd100, 32'd7);        check_out("divu", 32'd14, 0, 0, 0, 33);           retire("divu");
    issue(4'b0101, 32'd100, 32'd7);        check_out("remu", 32'd2, 0, 0, 0, 33);            retire("remu");
    issue(4'b0100, 32'd100, 32'd0);        check_out("divu0", 32'hFFFF_FFFF, 0, 0, 0, 33);   retire("divu0");
    issue(4'b0101, 32'd100, 32'd0);        check_out("remu0", 32'd100, 0, 0, 0, 33);         retire("remu0");
    issue(4'b0101, 32'd21, 32'd7);         check_out("remu_z", 32'd0, 0, 1, 0, 33);          retire("remu_z");

    // Backpressure: result must hold while stray requests are offered.
    issue(4'b0100, 32'd100, 32'd7);
    chk("bp_res0", result, 32'd14);
    for (int i = 0; i < 5; i++) begin
      op = 4'b0010; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("bp_valid%0d", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_res%0d", i), result, 32'd14);
      chk($sformatf("bp_rdy%0d", i), {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    retire("bp");
    @(negedge clk);
    chk("bp_no_stray", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a MUL aborts it.
    @(negedge clk);
    op = 4'b0011; a = 32'hFFFF_FFFF; b = 32'h2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_res", result, 32'h0);
    chk("abort_zero", {31'b0, zero}, 32'd1);
    chk("abort_rdy", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", {31'b0, in_ready}, 32'd1);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    chk("abort_no_result", 32'(lat), 32'd0);
    issue(4'b0010, 32'd2, 32'd3);          check_out("post_add", 32'd5, 0, 0, 0, 1);        retire("post_add");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised multi-cycle ALU; successor to the single-cycle combinational ALU in the execute stage.
- Adds iterative multiply (MUL, low and high words) and unsigned divide/remainder (DIVU/REMU), signed and unsigned compare, arithmetic shift and an overflow flag.
- Sits between the decode/operand-select logic and writeback.
- Uses a valid/ready handshake on both sides so the pipeline can stall on long operations.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  4  operation code (package constants)
- a  in  WIDTH  operand 1
- b  in  WIDTH  operand 2 (immediate already extended upstream)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  primary result
- result_hi  out  WIDTH  MUL upper word; 0 for all other ops
- zero  out  1  result == 0
- ovf  out  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; in_ready=0 during reset, 1 first cycle after; out_valid=0; result, result_hi, ovf = 0; zero=1. Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Accept when in_valid&&in_ready and latch op/a/b.
    - Single-cycle op -> DONE next cycle (latency 1).
    - MUL/DIVU/REMU -> BUSY with counter=WIDTH.
  - BUSY: in_ready=0; one iteration per cycle, counter decrements; at counter==1 -> DONE. Total accept-to-out_valid = WIDTH+1 cycles (33 at default).
  - DONE: out_valid=1 and outputs stable until out_ready. On out_valid&&out_ready -> IDLE. No back-to-back accept in the DONE cycle.
- Op codes (4-bit): AND 0000, OR 0001, ADD 0010, MUL 0011, DIVU 0100, REMU 0101, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010, SLTU 1011, NOR 1100 (true ~(a|b)).
  - Any other code: single-cycle, result=0, zero=1.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH. ovf = signed overflow of the operation.
  - SLT is signed, SLTU unsigned; result 1 or 0.
  - Shifts use b[SHW-1:0] only; SRA replicates the sign bit.
  - MUL is unsigned shift-add: {result_hi,result} = a*b (2*WIDTH bits).
  - DIVU/REMU use restoring division, one quotient bit per cycle.
  - b==0: DIVU result = all ones, REMU result = a. Still takes WIDTH+1 cycles.
- zero is computed from result only, never from result_hi.
- in_valid while BUSY or DONE is ignored; the upstream holds the request.

Decomposition:
- Package alu_pkg: op-code localparams, FSM state enum, op-class function is_multicycle(op).
- Sub-module alu_muldiv_core: iterative shift-add/restoring-divide datapath with start, busy, done, counter and working registers.
- Top module holds the FSM, handshake, single-cycle datapath and output registers.

Test Plan (WIDTH=32):
- Reset then ADD a=0x7FFFFFFF, b=1 -> after 1 cycle out_valid=1, result=0x80000000, ovf=1, zero=0. SUB a=5, b=5 -> result=0, zero=1, ovf=0.
- SLT a=0xFFFFFFFF, b=1 -> result=1. SLTU same operands -> 0. SRA a=0x80000000, b=0x21 -> 0xC0000000 (shift 1). NOR a=0, b=0 -> 0xFFFFFFFF.
- MUL a=0xFFFFFFFF, b=2 -> out_valid exactly 33 cycles after accept, result=0xFFFFFFFE, result_hi=1. in_ready=0 throughout BUSY.
- DIVU a=100, b=7 -> 14. REMU a=100, b=7 -> 2. DIVU b=0 -> 0xFFFFFFFF. REMU b=0 -> 100.
- Backpressure: out_ready=0 for 5 cycles after a DIVU completes -> out_valid and result held constant, in_ready=0, extra in_valid pulses ignored. After the out_ready handshake -> in_ready=1 next cycle.
- Assert rst_n=0 at cycle 10 of a MUL -> next cycle out_valid=0, state IDLE, result=0, zero=1. A following ADD 2+3 -> result=5.
